// File: rtl/mem_readback_dump_if.sv
// Request / response / output-stream bundle for mem_readback_dump.
// The master modport is the readback engine; the slave modport is the
// memory model plus the stream consumer.
interface mem_readback_dump_if #(
  parameter int unsigned AddrWidth = 48,
  parameter int unsigned DataWidth = 64
);
  // Read request channel (valid/ready)
  logic                 req_valid_o;
  logic                 req_ready_i;
  logic [AddrWidth-1:0] req_addr_o;
  // Read response channel (in order, no backpressure)
  logic                 rsp_valid_i;
  logic [DataWidth-1:0] rsp_data_i;
  // Output word stream (valid/ready)
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [DataWidth-1:0] out_data_o;
  logic                 out_last_o;

  modport master (
    output req_valid_o, req_addr_o,
    input  req_ready_i,
    input  rsp_valid_i, rsp_data_i,
    output out_valid_o, out_data_o, out_last_o,
    input  out_ready_i
  );

  modport slave (
    input  req_valid_o, req_addr_o,
    output req_ready_i,
    output rsp_valid_i, rsp_data_i,
    input  out_valid_o, out_data_o, out_last_o,
    output out_ready_i
  );
endinterface

// File: rtl/mem_readback_dump.sv
// Memory readback engine: on start, reads num_words consecutive words from
// base_addr, buffers responses in a small FIFO and streams them out with a
// last flag and a rotate-left-by-one / XOR running checksum.
// Credits (requests in flight + buffered words) are capped at MaxOutstanding,
// so the FIFO of that depth can never overflow.
// Optional simulation checks: define MEM_DUMP_ASSERT_EN.
module mem_readback_dump #(
  parameter int unsigned AddrWidth      = 48,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned LenWidth       = 32,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic [LenWidth-1:0]  num_words_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [DataWidth-1:0] checksum_o,
  mem_readback_dump_if.master  bus
);

  localparam int unsigned CntW         = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW         = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned BytesPerWord = DataWidth / 8;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t               r_state;
  logic [AddrWidth-1:0] r_req_addr;
  logic [LenWidth-1:0]  r_len;
  logic [LenWidth-1:0]  r_req_cnt;
  logic [LenWidth-1:0]  r_out_cnt;
  logic [DataWidth-1:0] r_checksum;
  logic [CntW-1:0]      r_credits;
  logic [CntW-1:0]      r_inflight;
  logic [CntW-1:0]      r_count;
  logic [PtrW-1:0]      r_wptr;
  logic [PtrW-1:0]      r_rptr;
  logic [DataWidth-1:0] r_mem [MaxOutstanding];

  logic w_req_fire;
  logic w_out_fire;
  logic w_push;
  logic w_pop;
  logic w_req_last;
  logic w_out_last;

  // Request is offered whenever issuing and a credit is free; credits only
  // drop on a handshake, so an offered request stays up until accepted.
  assign bus.req_valid_o = (r_state == S_ISSUE) && (r_credits != '0);
  assign bus.req_addr_o  = r_req_addr;
  assign bus.out_valid_o = (r_count != '0);
  assign bus.out_data_o  = r_mem[r_rptr];
  assign bus.out_last_o  = bus.out_valid_o && w_out_last;

  assign busy_o     = (r_state == S_ISSUE) || (r_state == S_DRAIN);
  assign done_o     = (r_state == S_DONE);
  assign checksum_o = r_checksum;

  assign w_req_fire = bus.req_valid_o && bus.req_ready_i;
  assign w_out_fire = bus.out_valid_o && bus.out_ready_i;
  // Responses with nothing in flight (e.g. stragglers after a reset) are dropped.
  assign w_push     = bus.rsp_valid_i && (r_inflight != '0);
  assign w_pop      = w_out_fire;
  assign w_req_last = (r_req_cnt == r_len - LenWidth'(1));
  assign w_out_last = (r_out_cnt == r_len - LenWidth'(1));

  // Transfer FSM: sequencing, address/length counters and checksum.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_req_addr <= '0;
      r_len      <= '0;
      r_req_cnt  <= '0;
      r_out_cnt  <= '0;
      r_checksum <= '0;
    end else begin
      if (w_out_fire) begin
        r_out_cnt  <= r_out_cnt + LenWidth'(1);
        r_checksum <= {r_checksum[DataWidth-2:0], r_checksum[DataWidth-1]} ^ bus.out_data_o;
      end
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_req_addr <= base_addr_i;
            r_len      <= num_words_i;
            r_req_cnt  <= '0;
            r_out_cnt  <= '0;
            r_checksum <= '0;
            r_state    <= (num_words_i == '0) ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_req_fire) begin
            r_req_cnt  <= r_req_cnt + LenWidth'(1);
            r_req_addr <= r_req_addr + AddrWidth'(BytesPerWord);
            if (w_req_last) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_out_fire && w_out_last) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Credit, in-flight and FIFO occupancy bookkeeping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_credits  <= CntW'(MaxOutstanding);
      r_inflight <= '0;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else begin
      case ({w_req_fire, w_pop})
        2'b10:   r_credits <= r_credits - CntW'(1);
        2'b01:   r_credits <= r_credits + CntW'(1);
        default: r_credits <= r_credits;
      endcase
      case ({w_req_fire, w_push})
        2'b10:   r_inflight <= r_inflight + CntW'(1);
        2'b01:   r_inflight <= r_inflight - CntW'(1);
        default: r_inflight <= r_inflight;
      endcase
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
      if (w_push) r_wptr <= (r_wptr == PtrW'(MaxOutstanding - 1)) ? '0 : r_wptr + PtrW'(1);
      if (w_pop)  r_rptr <= (r_rptr == PtrW'(MaxOutstanding - 1)) ? '0 : r_rptr + PtrW'(1);
    end
  end

  // FIFO storage; cleared on reset so the idle output word reads as zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < MaxOutstanding; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wptr] <= bus.rsp_data_i;
    end
  end

`ifdef MEM_DUMP_ASSERT_EN
  // Protocol sanity checks on responses and start requests.
  always @(posedge clk_i) begin
    if (!rst_i) begin
      if (bus.rsp_valid_i && (r_inflight == '0))
        $error("mem_readback_dump: response with nothing in flight");
      if (start_i && (r_state == S_IDLE) &&
          ((base_addr_i % AddrWidth'(BytesPerWord)) != '0))
        $error("mem_readback_dump: unaligned base address %h", base_addr_i);
      if (start_i && (r_state != S_IDLE))
        $warning("mem_readback_dump: start ignored while busy");
    end
  end

  a_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (bus.req_valid_o && !bus.req_ready_i) |=> (bus.req_valid_o && $stable(bus.req_addr_o)));

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(w_push && !w_pop && (r_count == CntW'(MaxOutstanding))));
`endif

endmodule
